// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: types and constants shared by the multiplier scheduler.
// The lane count and lane width come from the global PARALLEL_ORDER and
// MULT_DATA_WIDTH macros. Defaults apply only when nobody has defined them.
`ifndef PARALLEL_ORDER
`define PARALLEL_ORDER 4
`endif
`ifndef MULT_DATA_WIDTH
`define MULT_DATA_WIDTH 16
`endif

package mult_sched_pkg;

  localparam int MULT_LAT_DEFAULT = 3;
  localparam int LANES            = `PARALLEL_ORDER;
  localparam int LANE_W           = `MULT_DATA_WIDTH;

  // Wide enough for the largest supported requester count (16).
  localparam int TAG_ID_W         = 4;

  typedef logic [LANES-1:0][LANE_W-1:0] opvec_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } sched_tag_t;

endpackage

// File: rtl/mult_sched_rr_arb.sv
// rr_arb: NUM_REQ-wide round-robin arbiter with a registered pointer.
// Grants are combinational and at most one-hot. No grant is issued while
// en is low or reset is asserted.
// Optional macro MULT_SCHED_PRIO_EN gives requester 0 strict priority.
// In that mode, round-robin covers requesters 1..NUM_REQ-1 only, and a
// grant to requester 0 never moves the pointer.
module rr_arb
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_vld,
  output logic [ID_W-1:0]    o_grant_id
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_adv;

  // Pick the first valid requester at or after the pointer, wrapping around.
  always_comb begin
    o_grant     = '0;
    o_grant_vld = 1'b0;
    o_grant_id  = '0;
    w_cand      = '0;
    w_adv       = 1'b0;
    if (i_en && i_rst_n) begin
`ifdef MULT_SCHED_PRIO_EN
      if (i_valid[0]) begin
        o_grant_vld = 1'b1;
        o_grant[0]  = 1'b1;
      end
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
        w_cand = ID_W'((int'(r_ptr) + i) % NUM_REQ);
`ifdef MULT_SCHED_PRIO_EN
        if (!o_grant_vld && i_valid[w_cand] && (w_cand != '0)) begin
`else
        if (!o_grant_vld && i_valid[w_cand]) begin
`endif
          o_grant_vld     = 1'b1;
          o_grant_id      = w_cand;
          o_grant[w_cand] = 1'b1;
        end
      end
`ifdef MULT_SCHED_PRIO_EN
      w_adv = o_grant_vld && (o_grant_id != '0);
`else
      w_adv = o_grant_vld;
`endif
    end
  end

  // After each round-robin grant, the pointer moves to one past the winner.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_adv) begin
      r_ptr <= ID_W'((int'(o_grant_id) + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/mult_sched.sv
// mult_sched: shares one pipelined multi-lane multiplier array among
// NUM_REQ requesters. The granted operands are registered into the array.
// A {valid, id} tag rides alongside each issue through MULT_LAT+1 stages,
// so every product comes back labelled with the requester that issued it.
// Optional macro MULT_SCHED_PRIO_EN: requester 0 has strict priority
// (implemented inside rr_arb).
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_en,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  input  logic [NUM_REQ-1:0][LANES-1:0][LANE_W-1:0] i_req_opa,
  input  logic [NUM_REQ-1:0][LANES-1:0][LANE_W-1:0] i_req_opb,
  output logic [LANES-1:0][LANE_W-1:0]          o_mult_opa,
  output logic [LANES-1:0][LANE_W-1:0]          o_mult_opb,
  input  logic [LANES-1:0][LANE_W-1:0]          i_mult_out,
  output logic                                  o_rsp_valid,
  output logic [ID_W-1:0]                       o_rsp_id,
  output logic [LANES-1:0][LANE_W-1:0]          o_rsp_data,
  output logic                                  o_idle
);

  logic            w_grant_vld;
  logic [ID_W-1:0] w_grant_id;
  logic            w_busy_next;
  logic            w_unused_tail_id;
  opvec_t          r_opa;
  opvec_t          r_opb;
  logic            r_idle;
  sched_tag_t      r_tag [MULT_LAT+1];

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_valid     (i_req_valid),
    .o_grant     (o_req_ready),
    .o_grant_vld (w_grant_vld),
    .o_grant_id  (w_grant_id)
  );

  // Register the winner's operands into the array. Drive zeros when nothing is granted, to keep the array quiet.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_opa <= '0;
      r_opb <= '0;
    end else if (w_grant_vld) begin
      r_opa <= i_req_opa[w_grant_id];
      r_opb <= i_req_opb[w_grant_id];
    end else begin
      r_opa <= '0;
      r_opb <= '0;
    end
  end

  // Shift the tag pipe every cycle. Reset drops all tags, which masks stale array data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= MULT_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_grant_vld, id: TAG_ID_W'(w_grant_id)};
      for (int k = 1; k <= MULT_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Work remains after this edge if a new issue enters, or a tag is still short of the tail.
  always_comb begin
    w_busy_next = w_grant_vld;
    for (int k = 0; k < MULT_LAT; k++) begin
      w_busy_next = w_busy_next | r_tag[k].valid;
    end
  end

  // Register idle so that it updates in the same cycle as the pipeline state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idle <= 1'b1;
    end else begin
      r_idle <= !w_busy_next;
    end
  end

  assign w_unused_tail_id = ^r_tag[MULT_LAT].id;
  assign o_mult_opa       = r_opa;
  assign o_mult_opb       = r_opb;
  assign o_rsp_valid      = r_tag[MULT_LAT].valid;
  assign o_rsp_id         = r_tag[MULT_LAT].id[ID_W-1:0];
  assign o_rsp_data       = r_tag[MULT_LAT].valid ? i_mult_out : '0;
  assign o_idle           = r_idle;

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed testbench for mult_sched, using a lane-wise
// multiplier array model with a latency of three cycles.
// Operand setup: requester r has opa lane0 = r+1, opb lane0 = 5,
// opa lane1 = 100 and opb lane1 = r.
// So the expected products are lane0 = 5*(r+1) and lane1 = 100*r.
// If MULT_SCHED_PRIO_EN is defined, the priority sequence runs instead of the pure round-robin sequences.
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;

  logic                                   clk = 1'b0;
  logic                                   rstN;
  logic                                   en;
  logic [NREQ-1:0]                        reqValid;
  logic [NREQ-1:0]                        reqReady;
  logic [NREQ-1:0][LANES-1:0][LANE_W-1:0] reqOpa;
  logic [NREQ-1:0][LANES-1:0][LANE_W-1:0] reqOpb;
  opvec_t                                 multOpa;
  opvec_t                                 multOpb;
  opvec_t                                 multOut;
  opvec_t                                 rspData;
  opvec_t                                 pipe1 = '0;
  opvec_t                                 pipe2 = '0;
  opvec_t                                 pipe3 = '0;
  logic                                   rspValid;
  logic [IDW-1:0]                         rspId;
  logic                                   idle;
  int                                     testCount = 0;
  int                                     failCount = 0;
  logic [3:0]                             expReady;

  mult_sched #(
    .NUM_REQ  (NREQ),
    .MULT_LAT (LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_en        (en),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_opa   (reqOpa),
    .i_req_opb   (reqOpb),
    .o_mult_opa  (multOpa),
    .o_mult_opb  (multOpb),
    .i_mult_out  (multOut),
    .o_rsp_valid (rspValid),
    .o_rsp_id    (rspId),
    .o_rsp_data  (rspData),
    .o_idle      (idle)
  );

  always #5 clk = ~clk;

  function automatic opvec_t laneMul(input opvec_t a, input opvec_t b);
    opvec_t p;
    for (int l = 0; l < LANES; l++) p[l] = LANE_W'(a[l] * b[l]);
    return p;
  endfunction

  // Array model: the product appears three cycles after the operand register output.
  always @(posedge clk) begin
    pipe1 <= laneMul(multOpa, multOpb);
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign multOut = pipe3;

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] v);
    en       = e;
    reqValid = v;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input bit expValid, input int expId);
    checkOutput({tag, " rsp_valid"}, 64'(rspValid), 64'(expValid));
    if (expValid) begin
      checkOutput({tag, " rsp_id"}, 64'(rspId), 64'(expId));
      checkOutput({tag, " lane0"}, 64'(rspData[0]), 64'(5 * (expId + 1)));
    end else begin
      checkOutput({tag, " rsp_data"}, 64'(rspData), 64'(0));
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(1'b1, 4'h0);
    nextCycle();
    rstN = 1'b1;
  endtask

  // Watchdog: stop a runaway simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    rstN     = 1'b0;
    en       = 1'b1;
    reqValid = 4'hF;
    for (int r = 0; r < NREQ; r++) begin
      reqOpa[r]    = '0;
      reqOpb[r]    = '0;
      reqOpa[r][0] = LANE_W'(r + 1);
      reqOpb[r][0] = LANE_W'(5);
      reqOpa[r][1] = LANE_W'(100);
      reqOpb[r][1] = LANE_W'(r);
    end

    // Reset state.
    nextCycle();
    checkOutput("reset mult_opa", 64'(multOpa), 64'(0));
    checkOutput("reset mult_opb", 64'(multOpb), 64'(0));
    checkOutput("reset rsp_valid", 64'(rspValid), 64'(0));
    checkOutput("reset rsp_id", 64'(rspId), 64'(0));
    checkOutput("reset idle", 64'(idle), 64'(1));
    applyStimulus(1'b1, 4'hF);
    checkOutput("reset ready", 64'(reqReady), 64'(0));
    nextCycle();

    // Single grant to requester 2.
    rstN = 1'b1;
    applyStimulus(1'b1, 4'b0100);
    checkOutput("single ready", 64'(reqReady), 64'(4'b0100));
    nextCycle();
    checkOutput("single opa lane0", 64'(multOpa[0]), 64'(3));
    checkOutput("single opb lane0", 64'(multOpb[0]), 64'(5));
    checkOutput("single idle busy", 64'(idle), 64'(0));
    checkRsp("single t+1", 1'b0, 0);
    applyStimulus(1'b1, 4'h0);
    nextCycle();
    checkRsp("single t+2", 1'b0, 0);
    nextCycle();
    checkRsp("single t+3", 1'b0, 0);
    nextCycle();
    checkRsp("single t+4", 1'b1, 2);
    checkOutput("single lane1", 64'(rspData[1]), 64'(200));
    checkOutput("single idle t+4", 64'(idle), 64'(0));
    nextCycle();
    checkRsp("single t+5", 1'b0, 0);
    checkOutput("single idle t+5", 64'(idle), 64'(1));
    checkOutput("single opa quiet", 64'(multOpa), 64'(0));

`ifdef MULT_SCHED_PRIO_EN
    // Priority: requester 0 wins while valid, then 1..3 rotate.
    doReset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) nextCycle();
      case (c)
        4, 5, 6, 7: checkRsp($sformatf("prio c%0d", c), 1'b1, 0);
        8:          checkRsp($sformatf("prio c%0d", c), 1'b1, 1);
        9:          checkRsp($sformatf("prio c%0d", c), 1'b1, 2);
        10:         checkRsp($sformatf("prio c%0d", c), 1'b1, 3);
        11:         checkRsp($sformatf("prio c%0d", c), 1'b1, 1);
        default:    checkRsp($sformatf("prio c%0d", c), 1'b0, 0);
      endcase
      applyStimulus(1'b1, (c < 4) ? 4'hF : ((c < 8) ? 4'b1110 : 4'h0));
      case (c)
        0, 1, 2, 3: expReady = 4'b0001;
        4, 7:       expReady = 4'b0010;
        5:          expReady = 4'b0100;
        6:          expReady = 4'b1000;
        default:    expReady = 4'b0000;
      endcase
      checkOutput($sformatf("prio ready c%0d", c), 64'(reqReady), 64'(expReady));
    end
    checkOutput("prio idle end", 64'(idle), 64'(1));
`else
    // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3 and contiguous responses.
    doReset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) nextCycle();
      checkRsp($sformatf("rr c%0d", c), (c >= 4) && (c <= 11), (c - 4) % 4);
      checkOutput($sformatf("rr idle c%0d", c), 64'(idle), 64'((c == 0) || (c >= 12)));
      applyStimulus(1'b1, (c < 8) ? 4'hF : 4'h0);
      expReady = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checkOutput($sformatf("rr ready c%0d", c), 64'(reqReady), 64'(expReady));
    end

    // en dropped with three issues in flight.
    for (int c = 0; c <= 7; c++) begin
      nextCycle();
      checkRsp($sformatf("en c%0d", c), (c >= 4) && (c <= 6), c - 4);
      checkOutput($sformatf("en idle c%0d", c), 64'(idle), 64'((c == 0) || (c >= 7)));
      applyStimulus(c < 3, 4'hF);
      expReady = (c < 3) ? (4'b0001 << c) : 4'b0000;
      checkOutput($sformatf("en ready c%0d", c), 64'(reqReady), 64'(expReady));
    end

    // Reset while four tags are in flight (the pointer starts at 3).
    for (int c = 0; c <= 9; c++) begin
      nextCycle();
      rstN = (c != 4);
      if (c == 4)      checkRsp($sformatf("rst c%0d", c), 1'b1, 3);
      else if (c == 9) checkRsp($sformatf("rst c%0d", c), 1'b1, 0);
      else             checkRsp($sformatf("rst c%0d", c), 1'b0, 0);
      if (c == 5) begin
        checkOutput("rst idle", 64'(idle), 64'(1));
        checkOutput("rst opa", 64'(multOpa), 64'(0));
      end
      applyStimulus(1'b1, (c <= 5) ? 4'hF : 4'h0);
      case (c)
        0:       expReady = 4'b1000;
        1, 5:    expReady = 4'b0001;
        2:       expReady = 4'b0010;
        3:       expReady = 4'b0100;
        default: expReady = 4'b0000;
      endcase
      checkOutput($sformatf("rst ready c%0d", c), 64'(reqReady), 64'(expReady));
    end

    // Lone requester 3 for five cycles; then the pointer is 0, so the all-valid grant goes to 0.
    for (int c = 0; c <= 9; c++) begin
      nextCycle();
      if (c == 0) checkOutput("lone idle start", 64'(idle), 64'(1));
      if (c == 9)      checkRsp($sformatf("lone c%0d", c), 1'b1, 0);
      else             checkRsp($sformatf("lone c%0d", c), (c >= 4), 3);
      applyStimulus(1'b1, (c < 5) ? 4'b1000 : ((c == 5) ? 4'hF : 4'h0));
      expReady = (c < 5) ? 4'b1000 : ((c == 5) ? 4'b0001 : 4'b0000);
      checkOutput($sformatf("lone ready c%0d", c), 64'(reqReady), 64'(expReady));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
